layer_local_ctrl: RTL and testbench

//  Per-layer local sequencer: the responder to the global controller's local_en/clear_local outputs.

---
 rtl/layer_local_ctrl.sv | 154 +++++++++++++++
 tb/tb_layer_local_ctrl.sv | 255 +++++++++++++++++++++++++
 2 files changed

// File: rtl/layer_local_ctrl.sv
// Per-layer local sequencer: walks input/weight BRAM addresses for one dense layer,
// tags the MAC pipeline with first/last markers and reports completion upstream.
module layer_local_ctrl #(
    parameter int N_IN   = 8,
    parameter int N_OUT  = 4,
    parameter int RD_LAT = 1
) (
    input  logic                                         clk_i,
    input  logic                                         rstn_i,
    input  logic                                         local_en_i,
    input  logic                                         clear_i,
    output logic                                         rd_en_o,
    output logic [$clog2(N_IN)-1:0]                      in_addr_o,
    output logic [$clog2(N_IN*N_OUT)-1:0]                w_addr_o,
    output logic                                         mac_valid_o,
    output logic                                         mac_first_o,
    output logic                                         mac_last_o,
    output logic                                         out_we_o,
    output logic [((N_OUT > 1) ? $clog2(N_OUT) : 1)-1:0] out_idx_o,
    output logic                                         pu_next_en_o,
    output logic                                         done_o
);

    localparam int IW = $clog2(N_IN);
    localparam int WW = $clog2(N_IN * N_OUT);
    localparam int OW = (N_OUT > 1) ? $clog2(N_OUT) : 1;

    typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;

    state_t        state;
    state_t        state_nxt;
    logic [IW-1:0] i_cnt;
    logic [OW-1:0] o_cnt;
    logic [WW-1:0] w_cnt;
    logic          rd_first;
    logic          rd_last;
    logic [OW-1:0] rd_o;
    logic          flush;
    logic          issue;
    logic          last_i;
    logic          last_o;
    logic          last_issue;
    logic          final_we;

    logic          pv [RD_LAT];
    logic          pf [RD_LAT];
    logic          pl [RD_LAT];
    logic [OW-1:0] po [RD_LAT];

    assign flush      = !rstn_i || clear_i;
    assign issue      = (state == RUN) && local_en_i;
    assign last_i     = (i_cnt == IW'(N_IN - 1));
    assign last_o     = (o_cnt == OW'(N_OUT - 1));
    assign last_issue = issue && last_i && last_o;
    assign final_we   = out_we_o && (out_idx_o == OW'(N_OUT - 1));

    always_ff @(posedge clk_i) begin
        if (flush) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (local_en_i) state_nxt = RUN;
            RUN:     if (last_issue) state_nxt = DRAIN;
            DRAIN:   if (final_we) state_nxt = DONE;
            DONE:    state_nxt = DONE;
            default: state_nxt = IDLE;
        endcase
    end

    assign done_o = (state == DONE);

    // Term/output counters plus a linear weight address that equals o*N_IN + i.
    always_ff @(posedge clk_i) begin
        if (flush) begin
            i_cnt <= '0;
            o_cnt <= '0;
            w_cnt <= '0;
        end else if (issue) begin
            i_cnt <= last_i ? '0 : i_cnt + 1'b1;
            if (last_i) begin
                o_cnt <= last_o ? '0 : o_cnt + 1'b1;
            end
            w_cnt <= last_issue ? '0 : w_cnt + 1'b1;
        end
    end

    always_ff @(posedge clk_i) begin
        if (flush) begin
            rd_en_o   <= 1'b0;
            in_addr_o <= '0;
            w_addr_o  <= '0;
            rd_first  <= 1'b0;
            rd_last   <= 1'b0;
            rd_o      <= '0;
        end else begin
            rd_en_o <= issue;
            if (issue) begin
                in_addr_o <= i_cnt;
                w_addr_o  <= w_cnt;
                rd_first  <= (i_cnt == '0);
                rd_last   <= last_i;
                rd_o      <= o_cnt;
            end
        end
    end

    // Tags travel alongside the BRAM read; the pipeline never stalls, only a flush drops it.
    always_ff @(posedge clk_i) begin
        if (flush) begin
            for (int k = 0; k < RD_LAT; k++) begin
                pv[k] <= 1'b0;
                pf[k] <= 1'b0;
                pl[k] <= 1'b0;
                po[k] <= '0;
            end
        end else begin
            pv[0] <= rd_en_o;
            pf[0] <= rd_en_o && rd_first;
            pl[0] <= rd_en_o && rd_last;
            po[0] <= rd_o;
            for (int k = 1; k < RD_LAT; k++) begin
                pv[k] <= pv[k-1];
                pf[k] <= pf[k-1];
                pl[k] <= pl[k-1];
                po[k] <= po[k-1];
            end
        end
    end

    assign mac_valid_o = pv[RD_LAT-1];
    assign mac_first_o = pf[RD_LAT-1];
    assign mac_last_o  = pl[RD_LAT-1];

    always_ff @(posedge clk_i) begin
        if (flush) begin
            out_we_o     <= 1'b0;
            out_idx_o    <= '0;
            pu_next_en_o <= 1'b0;
        end else begin
            out_we_o <= mac_last_o;
            if (mac_last_o) begin
                out_idx_o <= po[RD_LAT-1];
            end
            pu_next_en_o <= pu_next_en_o || mac_last_o;
        end
    end

endmodule

// File: tb/tb_layer_local_ctrl.sv
// Randomized bench for layer_local_ctrl: a transaction-level model predicts reads,
// MAC tags and output strobes into queues that a negedge monitor pops and compares.
module tb_layer_local_ctrl;

  localparam int N_IN   = 8;
  localparam int N_OUT  = 4;
  localparam int RD_LAT = 1;
  localparam int TOTAL  = N_IN * N_OUT;
  localparam int unsigned BIG = 32'hFFFF_FFFF;

  localparam int N_IN2   = 2;
  localparam int N_OUT2  = 1;
  localparam int RD_LAT2 = 3;

  typedef struct packed {
    int unsigned cyc;
    logic [15:0] d;
  } ev_t;

  // clock / reset
  logic clk = 1'b0;
  always #5 clk = ~clk;

  int unsigned cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic       rstn, local_en, clear;
  logic       rd_en;
  logic [2:0] in_addr;
  logic [4:0] w_addr;
  logic       mac_valid, mac_first, mac_last, out_we;
  logic [1:0] out_idx;
  logic       pu_next_en, done;

  logic       rstn2, en2, clr2;
  logic       rd_en2;
  logic [0:0] in_addr2;
  logic [0:0] w_addr2;
  logic       mac_valid2, mac_first2, mac_last2, out_we2;
  logic [0:0] out_idx2;
  logic       pu2, done2;

  layer_local_ctrl #(.N_IN(N_IN), .N_OUT(N_OUT), .RD_LAT(RD_LAT)) u_dut (
    .clk_i(clk), .rstn_i(rstn), .local_en_i(local_en), .clear_i(clear),
    .rd_en_o(rd_en), .in_addr_o(in_addr), .w_addr_o(w_addr),
    .mac_valid_o(mac_valid), .mac_first_o(mac_first), .mac_last_o(mac_last),
    .out_we_o(out_we), .out_idx_o(out_idx), .pu_next_en_o(pu_next_en), .done_o(done)
  );

  layer_local_ctrl #(.N_IN(N_IN2), .N_OUT(N_OUT2), .RD_LAT(RD_LAT2)) u_dut_small (
    .clk_i(clk), .rstn_i(rstn2), .local_en_i(en2), .clear_i(clr2),
    .rd_en_o(rd_en2), .in_addr_o(in_addr2), .w_addr_o(w_addr2),
    .mac_valid_o(mac_valid2), .mac_first_o(mac_first2), .mac_last_o(mac_last2),
    .out_we_o(out_we2), .out_idx_o(out_idx2), .pu_next_en_o(pu2), .done_o(done2)
  );

  // scoreboard state
  int vectors = 0;
  int miscompares = 0;
  ev_t exp_rd_q[$];
  ev_t exp_mac_q[$];
  ev_t exp_we_q[$];

  logic        m_started;
  int          m_issued;
  int unsigned m_done_cyc;
  int unsigned m_pu_cyc;
  int unsigned m_zero_cyc;
  logic        small_done = 1'b0;

  task automatic check(input string name, input int unsigned c, input logic [31:0] act,
                       input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s cycle=%0d got=%0h expected=%0h", name, c, act, exp);
    end
  endtask

  // Reference model: decides what the layer does at the coming edge given this cycle's inputs.
  task automatic model_step(input logic en, input logic clr, input logic rst_n);
    int unsigned e;
    int k;
    ev_t ev;
    e = cyc + 1;
    if (!rst_n || clr) begin
      while (exp_rd_q.size() > 0 && exp_rd_q[$].cyc >= e) void'(exp_rd_q.pop_back());
      while (exp_mac_q.size() > 0 && exp_mac_q[$].cyc >= e) void'(exp_mac_q.pop_back());
      while (exp_we_q.size() > 0 && exp_we_q[$].cyc >= e) void'(exp_we_q.pop_back());
      m_started  = 1'b0;
      m_issued   = 0;
      m_done_cyc = BIG;
      m_pu_cyc   = BIG;
      m_zero_cyc = e;
    end else if (!m_started) begin
      if (en) m_started = 1'b1;
    end else if (m_issued < TOTAL && en) begin
      k = m_issued;
      ev.cyc = e;
      ev.d = {8'(k % N_IN), 8'(k)};
      exp_rd_q.push_back(ev);
      ev.cyc = e + RD_LAT;
      ev.d = {14'd0, (k % N_IN) == 0, (k % N_IN) == N_IN - 1};
      exp_mac_q.push_back(ev);
      if ((k % N_IN) == N_IN - 1) begin
        ev.cyc = e + RD_LAT + 1;
        ev.d = 16'(k / N_IN);
        exp_we_q.push_back(ev);
        if (m_pu_cyc == BIG) m_pu_cyc = e + RD_LAT + 1;
      end
      if (k == TOTAL - 1) m_done_cyc = e + RD_LAT + 2;
      m_issued++;
    end
  endtask

  // driver: inputs change just after the falling edge, after the monitor has sampled
  task automatic drive_cycle(input logic en, input logic clr, input logic rst_n);
    @(negedge clk);
    #1;
    local_en = en;
    clear    = clr;
    rstn     = rst_n;
    model_step(en, clr, rst_n);
  endtask

  // monitor
  ev_t  me;
  logic mx;
  always @(negedge clk) begin
    if (cyc >= 1) begin
      mx = (exp_rd_q.size() > 0) && (exp_rd_q[0].cyc == cyc);
      check("rd_en", cyc, 32'(rd_en), 32'(mx));
      if (mx) begin
        me = exp_rd_q.pop_front();
        if (rd_en) check("rd_addr", cyc, 32'({8'(in_addr), 8'(w_addr)}), 32'(me.d));
      end

      mx = (exp_mac_q.size() > 0) && (exp_mac_q[0].cyc == cyc);
      if (mx) begin
        me = exp_mac_q.pop_front();
        check("mac_vfl", cyc, 32'({mac_valid, mac_first, mac_last}), 32'({1'b1, me.d[1:0]}));
      end else begin
        check("mac_vfl", cyc, 32'({mac_valid, mac_first, mac_last}), 32'd0);
      end

      mx = (exp_we_q.size() > 0) && (exp_we_q[0].cyc == cyc);
      check("out_we", cyc, 32'(out_we), 32'(mx));
      if (mx) begin
        me = exp_we_q.pop_front();
        if (out_we) check("out_idx", cyc, 32'(out_idx), 32'(me.d));
      end

      check("done", cyc, 32'(done), 32'(cyc >= m_done_cyc));
      check("pu_next_en", cyc, 32'(pu_next_en), 32'(cyc >= m_pu_cyc));
      if (cyc == m_zero_cyc)
        check("zero_after_clear", cyc,
              32'({rd_en, in_addr, w_addr, mac_valid, mac_first, mac_last, out_we, out_idx,
                   pu_next_en, done}), 32'd0);
    end
  end

  // small configuration: fixed timeline derived from the latency rules
  initial begin : small_cfg
    int unsigned t0;
    int k;
    logic erd, emv, ef, el, ewe, edn;
    rstn2 = 1'b0;
    en2   = 1'b0;
    clr2  = 1'b0;
    @(negedge clk);
    #1;
    rstn2 = 1'b1;
    @(negedge clk);
    #1;
    en2 = 1'b1;
    t0 = cyc + 1;
    repeat (10) begin
      @(negedge clk);
      k   = int'(cyc) - int'(t0) - 1;
      erd = (k >= 0) && (k < N_IN2 * N_OUT2);
      k   = int'(cyc) - int'(t0) - 1 - RD_LAT2;
      emv = (k >= 0) && (k < N_IN2 * N_OUT2);
      ef  = emv && (k % N_IN2 == 0);
      el  = emv && (k % N_IN2 == N_IN2 - 1);
      k   = int'(cyc) - int'(t0) - 2 - RD_LAT2;
      ewe = (k >= 0) && (k < N_IN2 * N_OUT2) && (k % N_IN2 == N_IN2 - 1);
      edn = cyc >= t0 + N_IN2 * N_OUT2 + RD_LAT2 + 2;
      check("small_timeline", cyc, 32'({rd_en2, mac_valid2, mac_first2, mac_last2, out_we2, done2}),
            32'({erd, emv, ef, el, ewe, edn}));
    end
    small_done = 1'b1;
  end

  // stimulus
  initial begin : stim
    int p, mode, abort_at, stall;
    logic aborted, en, clr, rn;
    int leftover;
    local_en = 1'b0;
    clear    = 1'b0;
    rstn     = 1'b0;
    m_started  = 1'b0;
    m_issued   = 0;
    m_done_cyc = BIG;
    m_pu_cyc   = BIG;
    m_zero_cyc = 0;
    model_step(1'b0, 1'b0, 1'b0);

    for (int run = 0; run < 10; run++) begin
      aborted = 1'b0;
      stall   = 0;
      drive_cycle(1'b0, (run % 2) == 1, (run % 2) == 1);
      if (run == 2) begin
        drive_cycle(1'b1, 1'b1, 1'b1);
        drive_cycle(1'b0, 1'b0, 1'b1);
        drive_cycle(1'b0, 1'b0, 1'b1);
      end
      p        = (run < 2) ? 100 : $urandom_range(40, 95);
      mode     = (run < 2) ? 0 : $urandom_range(0, 3);
      abort_at = $urandom_range(3, 30);
      for (int n = 0; n < 600; n++) begin
        if (cyc >= m_done_cyc) break;
        en  = ($urandom_range(1, 100) <= p);
        clr = 1'b0;
        rn  = 1'b1;
        if (run == 1 && m_issued == 13 && stall < 3) begin
          en = 1'b0;
          stall++;
        end
        if (!aborted && mode == 1 && n == abort_at) begin
          clr = 1'b1;
          aborted = 1'b1;
        end
        if (!aborted && mode == 2 && m_issued == TOTAL) begin
          rn = 1'b0;
          aborted = 1'b1;
        end
        if (!aborted && mode == 3 && n == abort_at) begin
          rn = 1'b0;
          aborted = 1'b1;
        end
        drive_cycle(en, clr, rn);
      end
      repeat (4) drive_cycle(1'b1, 1'b0, 1'b1);
    end

    repeat (3) drive_cycle(1'b0, 1'b0, 1'b1);
    leftover = exp_rd_q.size() + exp_mac_q.size() + exp_we_q.size();
    check("queues_drained", cyc, 32'(leftover), 32'd0);
    check("small_cfg_finished", cyc, 32'(small_done), 32'd1);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
